// File: rtl/enemy_pkg.sv
// enemy_pkg: shared enemy group indices, group FSM state type and guard default
package enemy_pkg;
  localparam int FLY_FIRST_DEF = 0;
  localparam int FLY_LAST_DEF = 16;
  localparam int SPIDER_FIRST_DEF = 17;
  localparam int SPIDER_LAST_DEF = 20;
  localparam int MOSQ_FIRST_DEF = 21;
  localparam int MOSQ_LAST_DEF = 22;
  localparam int GUARD_CYCLES_DEF = 2;
  typedef enum logic [1:0] {SPAWN, GUARD, ACTIVE, WAIT} group_state_e;
endpackage

// File: rtl/enemy_group_respawn.sv
// enemy_group_respawn: one enemy group's respawn FSM and frame timer
// Ports: clk25/reset (async active-high); frame_tick, game_active, group_all_dead,
// delay (frames to wait) in; pulse = registered one-cycle respawn strobe out.
// WAVE_SPEEDUP_EN: when defined, delay is latched on entry to WAIT.
module enemy_group_respawn
  import enemy_pkg::*;
#(
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       game_active,
  input  logic       group_all_dead,
  input  logic [7:0] delay,
  output logic       pulse
);
  group_state_e state, state_n;
  logic [7:0] timer, timer_n, delay_q;
`ifdef WAVE_SPEEDUP_EN
  always_ff @(posedge clk25 or posedge reset)
    if (reset) delay_q <= '0;
    else if (state == ACTIVE && group_all_dead) delay_q <= delay;
`else
  assign delay_q = delay;
`endif
  // timer doubles as the guard counter and the frame counter
  always_comb begin
    state_n = state;
    timer_n = timer;
    case (state)
      SPAWN: begin
        state_n = GUARD;
        timer_n = '0;
      end
      GUARD: begin
        state_n = (timer == 8'(GUARD_CYCLES - 1)) ? ACTIVE : GUARD;
        timer_n = (timer == 8'(GUARD_CYCLES - 1)) ? '0 : timer + 8'd1;
      end
      ACTIVE: begin
        state_n = group_all_dead ? WAIT : ACTIVE;
        timer_n = '0;
      end
      WAIT: if (frame_tick && game_active) begin
        state_n = (timer == delay_q - 8'd1) ? SPAWN : WAIT;
        timer_n = (timer == delay_q - 8'd1) ? '0 : timer + 8'd1;
      end
      default: state_n = SPAWN;
    endcase
  end
  always_ff @(posedge clk25 or posedge reset)
    if (reset) begin
      state <= SPAWN;
      timer <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      pulse <= (state == SPAWN);
    end
endmodule

// File: rtl/enemy_wave_scheduler.sv
// enemy_wave_scheduler: group respawn sequencing plus kill and wave counting
// Ports: clk25/reset (async active-high); frame_tick, game_active, enemy_alive in;
// reset_fly/reset_spider/reset_mosquito respawn pulses, kill_count (saturating),
// wave_num (wrapping), all_clear pulse out.
// WAVE_SPEEDUP_EN: shortens the respawn delay by 8 frames per wave, floor 16.
module enemy_wave_scheduler
  import enemy_pkg::*;
#(
  parameter int ENEMY_COUNT = 23,
  parameter int FLY_FIRST = FLY_FIRST_DEF,
  parameter int FLY_LAST = FLY_LAST_DEF,
  parameter int SPIDER_FIRST = SPIDER_FIRST_DEF,
  parameter int SPIDER_LAST = SPIDER_LAST_DEF,
  parameter int MOSQ_FIRST = MOSQ_FIRST_DEF,
  parameter int MOSQ_LAST = MOSQ_LAST_DEF,
  parameter int RESPAWN_FRAMES = 120,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
  input  logic                   clk25,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   game_active,
  input  logic [ENEMY_COUNT-1:0] enemy_alive,
  output logic                   reset_fly,
  output logic                   reset_spider,
  output logic                   reset_mosquito,
  output logic [15:0]            kill_count,
  output logic [7:0]             wave_num,
  output logic                   all_clear
);
  localparam int KW = $clog2(ENEMY_COUNT + 1);
  logic [ENEMY_COUNT-1:0] prev_alive, dead_now;
  logic [KW-1:0] kills;
  logic [16:0] kill_sum;
  logic [7:0] delay;
  logic [2:0] grp_dead, pulses;
  logic clear_evt;
  assign dead_now = prev_alive & ~enemy_alive;
  always_comb begin
    kills = '0;
    for (int i = 0; i < ENEMY_COUNT; i++) kills = kills + KW'(dead_now[i]);
  end
  assign kill_sum = {1'b0, kill_count} + 17'(kills);
  assign clear_evt = ~|enemy_alive & |prev_alive;
  assign grp_dead = {~|enemy_alive[MOSQ_LAST:MOSQ_FIRST],
                     ~|enemy_alive[SPIDER_LAST:SPIDER_FIRST],
                     ~|enemy_alive[FLY_LAST:FLY_FIRST]};
`ifdef WAVE_SPEEDUP_EN
  logic [11:0] wave_x8;
  // compare before subtracting so the 12-bit difference never wraps
  assign wave_x8 = {1'b0, wave_num, 3'b000};
  assign delay = (wave_x8 + 12'd16 >= 12'(RESPAWN_FRAMES)) ? 8'd16 : 8'(12'(RESPAWN_FRAMES) - wave_x8);
`else
  assign delay = 8'(RESPAWN_FRAMES);
`endif
  for (genvar g = 0; g < 3; g++) begin : grp
    enemy_group_respawn #(.GUARD_CYCLES(GUARD_CYCLES)) u_grp (
      .clk25(clk25),
      .reset(reset),
      .frame_tick(frame_tick),
      .game_active(game_active),
      .group_all_dead(grp_dead[g]),
      .delay(delay),
      .pulse(pulses[g])
    );
  end
  assign {reset_mosquito, reset_spider, reset_fly} = pulses;
  always_ff @(posedge clk25 or posedge reset)
    if (reset) begin
      prev_alive <= '0;
      kill_count <= '0;
      wave_num <= '0;
      all_clear <= 1'b0;
    end else begin
      prev_alive <= enemy_alive;
      kill_count <= kill_sum[16] ? 16'hFFFF : kill_sum[15:0];
      wave_num <= wave_num + 8'(clear_evt);
      all_clear <= clear_evt;
    end
endmodule

// File: doc/enemy_wave_scheduler.md
Name: enemy_wave_scheduler

Overview:
- Sequences respawning of the three enemy groups (fly, spider, mosquito) around the enemy hit/alive register.
- Watches the registered alive vector. When a group is fully destroyed, waits a frame-based delay, then issues that group's one-cycle respawn pulse (reset_fly / reset_spider / reset_mosquito).
- Also counts kills and waves for the score/HUD logic.
- Sits between the hit-detection block and the game-state/HUD blocks.

Parameters:
- ENEMY_COUNT, 23, width of the alive vector.
- FLY_FIRST, 0, first fly index.
- FLY_LAST, 16, last fly index.
- SPIDER_FIRST, 17, first spider index.
- SPIDER_LAST, 20, last spider index.
- MOSQ_FIRST, 21, first mosquito index.
- MOSQ_LAST, 22, last mosquito index.
- RESPAWN_FRAMES, 120, frames to wait between group clear and its respawn pulse.
- GUARD_CYCLES, 2, cycles after a pulse during which clear detection for that group is masked (covers alive-register feedback latency).

Ports:
- clk25, input, 1, 25 MHz system clock.
- reset, input, 1, asynchronous, active-high reset.
- frame_tick, input, 1, one-cycle pulse per video frame.
- game_active, input, 1, when low all respawn timers freeze; kill counting continues.
- enemy_alive, input, ENEMY_COUNT, registered alive flags from the hit-detection block (bit i = enemy i).
- reset_fly, output, 1, one-cycle respawn pulse for indices FLY_FIRST..FLY_LAST.
- reset_spider, output, 1, one-cycle respawn pulse for the spider range.
- reset_mosquito, output, 1, one-cycle respawn pulse for the mosquito range.
- kill_count, output, 16, saturating total kills.
- wave_num, output, 8, count of full clears (all enemies dead); wraps at 255 -> 0.
- all_clear, output, 1, one-cycle pulse when all ENEMY_COUNT enemies become dead.

Behaviour:
- Reset (async, active-high) sets:
  - all outputs to 0;
  - prev_alive to all-zero;
  - every group FSM to SPAWN with timer 0.
- Per-group FSM, identical for all three groups; each advances independently.
  - SPAWN: at the first clk25 edge after reset release, assert that group's pulse for exactly one cycle, then go to GUARD.
  - GUARD: count GUARD_CYCLES clk25 cycles, ignoring alive state, then go to ACTIVE.
  - ACTIVE: if every bit in the group range is 0, go to WAIT with timer cleared.
  - WAIT: timer increments on frame_tick, only when game_active=1. When timer reaches RESPAWN_FRAMES-1 and frame_tick=1 (and game_active=1), go to SPAWN. Timer is 8 bits wide.
- Pulse timing:
  - The pulse output is registered: high in the cycle after the SPAWN state is entered.
  - Its duration is exactly one clk25 cycle.
  - Groups may pulse in the same cycle.
- Kill counting:
  - kills = popcount(prev_alive & ~enemy_alive), evaluated every cycle; prev_alive <= enemy_alive every cycle.
  - kill_count += kills, saturating at 16'hFFFF.
  - Multiple kills in one cycle (up to ENEMY_COUNT) are all counted.
  - Respawn (0->1) transitions are never counted.
- all_clear / wave_num:
  - all_clear pulses one cycle when enemy_alive == 0 and prev_alive != 0.
  - wave_num increments in the same cycle as the all_clear pulse.
- Edge cases:
  - game_active low in WAIT: timer holds its value; frame_tick is ignored.
  - Group cleared while another group is in WAIT: independent, no interaction.
  - Reset asserted mid-WAIT or mid-pulse: pulse drops immediately (async); all groups restart at SPAWN.
  - RESPAWN_FRAMES must be in 1..255. With 1, the respawn pulse follows the first frame_tick after the clear.

Optional Feature:
- Macro: WAVE_SPEEDUP_EN.
- Defined: effective delay = max(16, RESPAWN_FRAMES - 8*wave_num), computed with a 12-bit intermediate so it cannot underflow. The delay value is latched on WAIT entry.
- Undefined: delay is always RESPAWN_FRAMES, and no extra logic is built.

Decomposition:
- Shared package enemy_pkg holds:
  - the group index constants (FLY/SPIDER/MOSQ first/last);
  - the group FSM state enum (SPAWN, GUARD, ACTIVE, WAIT);
  - the constant GUARD_CYCLES default.
- Natural sub-module: enemy_group_respawn. It contains one group FSM plus its timer; inputs are group_all_dead, frame_tick, game_active and delay; output is the pulse. It is instantiated three times.
- The top level holds the range-reduction of enemy_alive, the popcount/kill logic and the wave logic.

Test Plan:
- Reset release -> reset_fly, reset_spider and reset_mosquito all high for exactly one cycle at the first edge. kill_count=0, wave_num=0.
- Clear bits 17..20 (others alive), RESPAWN_FRAMES=4, a frame_tick every 10 cycles -> reset_spider pulses once, one cycle after the 4th tick. No fly or mosquito pulse occurs. kill_count=4.
- In one cycle drop 3 fly bits and 2 mosquito bits -> kill_count increases by exactly 5. Setting those bits back to 1 leaves kill_count unchanged.
- All 23 bits go to 0 in one cycle -> all_clear pulses once and wave_num 0->1. All three groups enter WAIT and pulse on the same cycle.
- In WAIT at timer=2, drop game_active for 5 frame_ticks, then restore -> pulse is delayed by exactly 5 frames relative to the unpaused case.
- kill_count preloaded to 16'hFFFE, then 3 kills -> kill_count=16'hFFFF. With WAVE_SPEEDUP_EN defined, RESPAWN_FRAMES=40 and wave_num=5, the respawn occurs after 16 frames.
